// File: rtl/seq_codes_dec_pipe_if.sv
// Handshake bundle for seq_codes_dec_pipe: a code/mode input channel and a
// decoded-result output channel, both val/rdy.
interface seq_codes_dec_pipe_if #(
    parameter int nbits = 2,
    parameter int nouts = 2 ** nbits
);
    // A transfer happens on a rising edge where val && rdy; the sender holds
    // its payload stable until that edge, and rdy never depends on val.
    logic             in_val;
    logic             in_rdy;
    logic [nbits-1:0] in_;
    logic [1:0]       mode;
    logic             out_val;
    logic             out_rdy;
    logic [nouts-1:0] out;
    logic             out_err;
    logic [1:0]       count;

    modport master (
        output in_val, in_, mode, out_rdy,
        input  in_rdy, out_val, out, out_err, count
    );

    modport slave (
        input  in_val, in_, mode, out_rdy,
        output in_rdy, out_val, out, out_err, count
    );
endinterface

// File: rtl/seq_codes_dec_pipe.sv
// Binary-code decoder with four decode modes, decoding at enqueue time into a
// 2-entry val/rdy output queue; out-of-range codes are flagged with out_err.
module seq_codes_dec_pipe #(
    parameter int nbits = 2,
    parameter int nouts = 2 ** nbits
) (
    input  logic               clk,
    input  logic               reset,
    seq_codes_dec_pipe_if.slave io
);
    if (nbits < 1 || nbits > 8 || nouts < 2 || nouts > (1 << nbits)) begin : g_bad_params
        $error("seq_codes_dec_pipe: illegal nbits/nouts combination");
    end

    // Codes are widened by one bit so nouts itself and nouts-1-k are representable.
    typedef logic [nbits:0] code_t;
    localparam code_t NOUTS_W = code_t'(nouts);

    logic [nouts-1:0] data_q [2];
    logic [nouts-1:0] data_d [2];
    logic [1:0]       err_q, err_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             started_q, started_d;

    logic             enq, deq;
    code_t            k_ext, rev_k, idx;
    logic [nouts-1:0] dec_val;
    logic             dec_err;

    // started_q keeps in_rdy low while reset is held and for no longer.
    assign io.in_rdy  = started_q && (count_q != 2'd2);
    assign io.out_val = (count_q != 2'd0);
    assign io.out     = io.out_val ? data_q[head_q] : '0;
    assign io.out_err = io.out_val ? err_q[head_q] : 1'b0;
    assign io.count   = count_q;

    assign enq = io.in_val && io.in_rdy;
    assign deq = io.out_val && io.out_rdy;

    always_comb begin
        k_ext   = {1'b0, io.in_};
        rev_k   = NOUTS_W - code_t'(1) - k_ext;
        dec_val = '0;
        dec_err = 1'b0;
        idx     = '0;
        if (k_ext >= NOUTS_W) begin
            dec_err = 1'b1;
        end else begin
            for (int i = 0; i < nouts; i++) begin
                idx = code_t'(i);
                case (io.mode)
                    2'b00:   dec_val[i] = (idx == k_ext);
                    2'b01:   dec_val[i] = (idx <= k_ext);
                    2'b10:   dec_val[i] = (idx != k_ext);
                    default: dec_val[i] = (idx == rev_k);
                endcase
            end
        end
    end

    always_comb begin
        data_d    = data_q;
        err_d     = err_q;
        head_d    = head_q ^ deq;
        tail_d    = tail_q ^ enq;
        count_d   = count_q;
        started_d = 1'b1;
        if (enq) begin
            data_d[tail_q] = dec_val;
            err_d[tail_q]  = dec_err;
        end
        if (enq && !deq) begin
            count_d = count_q + 2'd1;
        end else if (!enq && deq) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            err_q     <= '0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
            started_q <= 1'b0;
        end else begin
            data_q[0] <= data_d[0];
            data_q[1] <= data_d[1];
            err_q     <= err_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            started_q <= started_d;
        end
    end
endmodule

// File: tb/tb_seq_codes_dec_pipe.sv
// Bench for seq_codes_dec_pipe: a 2-bit/4-output instance and a 3-bit/6-output
// instance, each with its own expected-result queue popped on every dequeue.
module tb_seq_codes_dec_pipe;
  localparam int W = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_codes_dec_pipe_if #(.nbits(2), .nouts(4)) ifa ();
  seq_codes_dec_pipe_if #(.nbits(3), .nouts(6)) ifb ();

  seq_codes_dec_pipe #(.nbits(2), .nouts(4)) dut_a (.clk(clk), .reset(reset), .io(ifa));
  seq_codes_dec_pipe #(.nbits(3), .nouts(6)) dut_b (.clk(clk), .reset(reset), .io(ifb));

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] ea, eb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: bit 8 is the error flag, bits 7:0 the decoded value.
  function automatic logic [W-1:0] model(input int code, input int md, input int no);
    logic [7:0] v;
    logic [7:0] mask;
    mask = 8'((9'd1 << no) - 9'd1);
    if (code >= no) return {1'b1, 8'h00};
    case (md)
      0:       v = 8'd1 << code;
      1:       v = (8'd2 << code) - 8'd1;
      2:       v = ~(8'd1 << code) & mask;
      default: v = 8'd1 << (no - 1 - code);
    endcase
    return {1'b0, v};
  endfunction

  // Scoreboards: compare the head on every cycle that ends in a dequeue.
  always @(negedge clk) begin
    if (reset && ifa.out_val && ifa.out_rdy) begin
      if (exp_a.size() == 0) check("a_unexpected_out", 32'(ifa.out), 0);
      else begin
        ea = exp_a.pop_front();
        check("a_head", {ifa.out_err, 8'(ifa.out)}, ea);
      end
    end
  end

  always @(negedge clk) begin
    if (reset && ifb.out_val && ifb.out_rdy) begin
      if (exp_b.size() == 0) check("b_unexpected_out", 32'(ifb.out), 0);
      else begin
        eb = exp_b.pop_front();
        check("b_head", {ifb.out_err, 8'(ifb.out)}, eb);
      end
    end
  end

  task automatic wait_acc_a();
    bit acc = 0;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      acc = ifa.in_rdy;
      @(posedge clk);
      #1;
    end
    check("a_accept", acc, 1);
  endtask

  task automatic wait_acc_b();
    bit acc = 0;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      acc = ifb.in_rdy;
      @(posedge clk);
      #1;
    end
    check("b_accept", acc, 1);
  endtask

  task automatic send_a(input int code, input int md);
    exp_a.push_back(model(code, md, 4));
    ifa.in_val = 1'b1;
    ifa.in_    = 2'(code);
    ifa.mode   = 2'(md);
    wait_acc_a();
    ifa.in_val = 1'b0;
  endtask

  task automatic send_b(input int code, input int md);
    exp_b.push_back(model(code, md, 6));
    ifb.in_val = 1'b1;
    ifb.in_    = 3'(code);
    ifb.mode   = 2'(md);
    wait_acc_b();
    ifb.in_val = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] m;
    ifa.in_val = 1'b0; ifa.in_ = '0; ifa.mode = '0; ifa.out_rdy = 1'b0;
    ifb.in_val = 1'b0; ifb.in_ = '0; ifb.mode = '0; ifb.out_rdy = 1'b0;

    // Reset state
    #2;
    check("rst_out_val", ifa.out_val, 0);
    check("rst_in_rdy", ifa.in_rdy, 0);
    check("rst_count", ifa.count, 0);
    check("rst_out", ifa.out, 0);
    check("rst_out_err", ifa.out_err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_rdy", ifa.in_rdy, 1);
    check("post_rst_out_val", ifa.out_val, 0);

    // One-hot stream with the consumer always ready
    ifa.out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_a(k, 0);
      m = model(k, 0, 4);
      check("stream_out", ifa.out, 32'(m[3:0]));
      check("stream_count", ifa.count, 1);
      check("stream_in_rdy", ifa.in_rdy, 1);
    end

    // Remaining decode modes
    send_a(2, 1); check("mode01_out", ifa.out, 4'b0111);
    send_a(2, 2); check("mode10_out", ifa.out, 4'b1011);
    send_a(2, 3); check("mode11_out", ifa.out, 4'b0010);
    send_a(0, 1); check("mode01_k0_out", ifa.out, 4'b0001);
    check("modes_err", ifa.out_err, 0);
    repeat (2) @(posedge clk);
    #1;
    check("drain_count", ifa.count, 0);
    check("drain_out", ifa.out, 0);

    // Backpressure: fill, hold a third input, then release
    ifa.out_rdy = 1'b0;
    send_a(1, 0);
    send_a(3, 0);
    check("full_count", ifa.count, 2);
    check("full_in_rdy", ifa.in_rdy, 0);
    check("full_head", ifa.out, 4'b0010);
    exp_a.push_back(model(0, 0, 4));
    ifa.in_val = 1'b1; ifa.in_ = 2'd0; ifa.mode = 2'd0;
    repeat (3) begin
      @(negedge clk);
      check("held_in_rdy", ifa.in_rdy, 0);
      check("held_count", ifa.count, 2);
      check("held_head", ifa.out, 4'b0010);
    end
    @(posedge clk); #1;
    ifa.out_rdy = 1'b1;
    @(negedge clk);
    check("release_in_rdy_still_low", ifa.in_rdy, 0);
    @(posedge clk); #1;
    check("release_in_rdy", ifa.in_rdy, 1);
    check("release_head", ifa.out, 4'b1000);
    wait_acc_a();
    ifa.in_val = 1'b0;
    check("simul_count", ifa.count, 1);
    check("simul_head", ifa.out, 4'b0001);
    @(posedge clk); #1;
    check("bp_drain_count", ifa.count, 0);

    // Non-power-of-two instance
    ifb.out_rdy = 1'b1;
    send_b(5, 0); check("b5_out", ifb.out, 6'b100000); check("b5_err", ifb.out_err, 0);
    send_b(6, 0); check("b6_out", ifb.out, 0); check("b6_err", ifb.out_err, 1);
    send_b(6, 1); check("b6m1_err", ifb.out_err, 1);
    send_b(7, 2); check("b7m2_out", ifb.out, 0); check("b7m2_err", ifb.out_err, 1);
    send_b(7, 3); check("b7m3_err", ifb.out_err, 1);
    send_b(1, 3); check("b1m3_out", ifb.out, 6'b010000); check("b1m3_err", ifb.out_err, 0);
    for (int n = 0; n < 6; n++) send_b($urandom_range(0, 7), $urandom_range(0, 3));
    repeat (2) @(posedge clk);
    #1;
    check("b_drain_count", ifb.count, 0);

    // Asynchronous reset while the queue is full
    ifa.out_rdy = 1'b0;
    send_a(2, 0);
    send_a(1, 0);
    check("pre_rst_count", ifa.count, 2);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_val", ifa.out_val, 0);
    check("mid_rst_count", ifa.count, 0);
    check("mid_rst_out", ifa.out, 0);
    check("mid_rst_out_err", ifa.out_err, 0);
    check("mid_rst_in_rdy", ifa.in_rdy, 0);
    exp_a.delete();
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rel_in_rdy", ifa.in_rdy, 1);
    check("rel_out_val", ifa.out_val, 0);

    check("a_queue_empty", exp_a.size(), 0);
    check("b_queue_empty", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
